// File: rtl/sap_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sap_clock_gate_ctrl
// Description : Per-domain clock-gating sequencer. Each domain is gated after
//               a sleep request plus a run of idle cycles, and reopens on a
//               wake event. A round-robin arbiter lets only one domain
//               through its wake window at a time to bound restart inrush.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_clock_gate_ctrl #(
    parameter int NUM_DOMAINS = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_en_i,
    input  logic [NUM_DOMAINS-1:0] sleep_req_i,
    input  logic [NUM_DOMAINS-1:0] idle_i,
    input  logic [NUM_DOMAINS-1:0] wake_i,
    output logic [NUM_DOMAINS-1:0] en_o,
    output logic [NUM_DOMAINS-1:0] gated_o,
    output logic [NUM_DOMAINS-1:0] wake_done_o
);

    localparam int c_MAX_CNT = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int c_CW      = $clog2(c_MAX_CNT + 1);
    localparam int c_PW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [c_CW-1:0] c_IDLE_LAST = c_CW'(IDLE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_WAKE_LAST = c_CW'(WAKE_CYCLES - 1);

    localparam logic [2:0] c_ST_ACTIVE    = 3'd0;
    localparam logic [2:0] c_ST_DRAIN     = 3'd1;
    localparam logic [2:0] c_ST_GATED     = 3'd2;
    localparam logic [2:0] c_ST_WAKE_PEND = 3'd3;
    localparam logic [2:0] c_ST_WAKE      = 3'd4;

    logic [NUM_DOMAINS-1:0] w_pend;     // domain waiting for a wake grant
    logic [NUM_DOMAINS-1:0] w_in_wake;  // domain currently in its wake window
    logic [NUM_DOMAINS-1:0] w_grant;
    logic                   w_grant_vld;
    logic [c_PW-1:0]        w_grant_nxt_ptr;
    logic [c_PW-1:0]        r_rr_ptr;

    // Round-robin pick of one pending domain, only while no wake is in progress
    always_comb begin
        w_grant         = '0;
        w_grant_vld     = 1'b0;
        w_grant_nxt_ptr = r_rr_ptr;
        if (w_in_wake == '0) begin
            for (int j = 0; j < NUM_DOMAINS; j++) begin
                if (!w_grant_vld && w_pend[(int'(r_rr_ptr) + j) % NUM_DOMAINS]) begin
                    w_grant_vld = 1'b1;
                    w_grant[(int'(r_rr_ptr) + j) % NUM_DOMAINS] = 1'b1;
                    w_grant_nxt_ptr = c_PW'((int'(r_rr_ptr) + j + 1) % NUM_DOMAINS);
                end
            end
        end
    end

    // Round-robin pointer advances past the domain just granted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_grant_vld) begin
            r_rr_ptr <= w_grant_nxt_ptr;
        end
    end

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        logic [2:0]      r_state;
        logic [c_CW-1:0] r_cnt;
        logic            r_wake_done;

        // Per-domain sleep/wake sequencer
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_state     <= c_ST_ACTIVE;
                r_cnt       <= '0;
                r_wake_done <= 1'b0;
            end else begin
                r_wake_done <= 1'b0;
                case (r_state)
                    c_ST_ACTIVE: begin
                        if (sleep_req_i[i] && !wake_i[i]) begin
                            r_state <= c_ST_DRAIN;
                            r_cnt   <= '0;
                        end
                    end
                    c_ST_DRAIN: begin
                        // A wake or dropped request beats a completed idle run
                        if (wake_i[i] || !sleep_req_i[i]) begin
                            r_state <= c_ST_ACTIVE;
                        end else if (idle_i[i] && (r_cnt == c_IDLE_LAST)) begin
                            r_state <= c_ST_GATED;
                        end else if (idle_i[i]) begin
                            r_cnt <= r_cnt + c_CW'(1);
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    c_ST_GATED: begin
                        if (wake_i[i] || !sleep_req_i[i]) begin
                            r_state <= c_ST_WAKE_PEND;
                        end
                    end
                    c_ST_WAKE_PEND: begin
                        if (w_grant[i]) begin
                            r_state <= c_ST_WAKE;
                            r_cnt   <= '0;
                        end
                    end
                    c_ST_WAKE: begin
                        if (r_cnt == c_WAKE_LAST) begin
                            r_state     <= c_ST_ACTIVE;
                            r_wake_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CW'(1);
                        end
                    end
                    default: begin
                        r_state <= c_ST_ACTIVE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        // Outputs decode straight from state flops so the gate enable is glitch-free
        assign w_pend[i]      = (r_state == c_ST_WAKE_PEND);
        assign w_in_wake[i]   = (r_state == c_ST_WAKE);
        assign en_o[i]        = (r_state == c_ST_ACTIVE) || (r_state == c_ST_DRAIN) ||
                                (r_state == c_ST_WAKE) || test_en_i;
        assign gated_o[i]     = (r_state == c_ST_GATED) || (r_state == c_ST_WAKE_PEND);
        assign wake_done_o[i] = r_wake_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_sap_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap_clock_gate_ctrl
// Description : Directed table-driven bench for sap_clock_gate_ctrl with
//               hand-written sequences for multi-cycle corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_clock_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       test_en = 1'b0;
    logic [3:0] sleep = 4'h0;
    logic [3:0] idle = 4'h0;
    logic [3:0] wake = 4'h0;
    logic [3:0] en;
    logic [3:0] gated;
    logic [3:0] done;

    int n_pass  = 0;
    int n_total = 0;

    sap_clock_gate_ctrl #(
        .NUM_DOMAINS(4),
        .IDLE_CYCLES(8),
        .WAKE_CYCLES(2)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .test_en_i  (test_en),
        .sleep_req_i(sleep),
        .idle_i     (idle),
        .wake_i     (wake),
        .en_o       (en),
        .gated_o    (gated),
        .wake_done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sleep;
        logic [3:0] idle;
        logic [3:0] wake;
        logic       ten;
        logic [3:0] en;
        logic [3:0] gated;
        logic [3:0] done;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic [3:0] s, logic [3:0] i, logic [3:0] w, logic t,
                                logic [3:0] e, logic [3:0] g, logic [3:0] d);
        vec_t v;
        v.sleep = s; v.idle = i; v.wake = w; v.ten = t;
        v.en = e; v.gated = g; v.done = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       dropped;
        logic [3:0] e_en, e_g, e_d;

        // Gate domain 0, test-mode override, wake and re-drain, release
        for (int n = 0; n < 8; n++) tbl[n] = mk(4'h1, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0);
        tbl[8]  = mk(4'h1, 4'hF, 4'h0, 1'b0, 4'hE, 4'h1, 4'h0);
        tbl[9]  = mk(4'h1, 4'hF, 4'h0, 1'b0, 4'hE, 4'h1, 4'h0);
        tbl[10] = mk(4'h1, 4'hF, 4'h0, 1'b1, 4'hF, 4'h1, 4'h0);
        tbl[11] = mk(4'h1, 4'hF, 4'h1, 1'b0, 4'hE, 4'h1, 4'h0);
        tbl[12] = mk(4'h1, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0);
        tbl[13] = mk(4'h1, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0);
        tbl[14] = mk(4'h1, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h1);
        tbl[15] = mk(4'h1, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0);
        tbl[16] = mk(4'h0, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0);

        // Reset state
        step(); step();
        chk("rst_en", en, 4'hF);
        chk("rst_gated", gated, 4'h0);
        chk("rst_done", done, 4'h0);
        rst = 1'b0;
        step();
        chk("post_rst_en", en, 4'hF);

        // Table-driven vectors
        for (int n = 0; n < 17; n++) begin
            sleep = tbl[n].sleep; idle = tbl[n].idle;
            wake = tbl[n].wake; test_en = tbl[n].ten;
            step();
            chk($sformatf("tbl%0d_en", n), en, tbl[n].en);
            chk($sformatf("tbl%0d_gated", n), gated, tbl[n].gated);
            chk($sformatf("tbl%0d_done", n), done, tbl[n].done);
        end
        test_en = 1'b0; wake = 4'h0;

        // Idle drop at cycle 5 restarts the count: gating moves to cycle 14
        for (int c = 0; c < 14; c++) begin
            sleep = 4'h1;
            idle  = (c == 5) ? 4'hE : 4'hF;
            step();
            if (c + 1 == 9)  chk("idrop_c9_gated", gated, 4'h0);
            if (c + 1 == 13) chk("idrop_c13_gated", gated, 4'h0);
            if (c + 1 == 14) begin
                chk("idrop_c14_gated", gated, 4'h1);
                chk("idrop_c14_en", en, 4'hE);
            end
        end
        sleep = 4'h0;
        for (int c = 0; c < 6; c++) step();
        chk("idrop_recover_en", en, 4'hF);

        // Abort in DRAIN: domain 1 enable never drops
        dropped = 1'b0;
        for (int c = 0; c < 12; c++) begin
            sleep = (c < 4) ? 4'h2 : 4'h0;
            step();
            if (!en[1] || gated[1]) dropped = 1'b1;
        end
        chk("abort_drain_en1_held", {3'b0, dropped}, 4'h0);

        // Wake with sleep in ACTIVE keeps the domain active
        sleep = 4'h8; wake = 4'h8;
        for (int c = 0; c < 12; c++) step();
        chk("act_wake_gated", gated, 4'h0);
        chk("act_wake_en", en, 4'hF);
        sleep = 4'h0; wake = 4'h0;
        step();

        // Wake on final qualifying DRAIN cycle wins
        for (int c = 0; c < 9; c++) begin
            sleep = 4'h2;
            wake  = (c == 8) ? 4'h2 : 4'h0;
            step();
        end
        chk("lastdrain_wake_gated", gated, 4'h0);
        chk("lastdrain_wake_en", en, 4'hF);
        sleep = 4'h0; wake = 4'h0;
        step(); step();

        // Wake latency for domain 2
        sleep = 4'h4;
        for (int c = 0; c < 9; c++) step();
        chk("d2_gated", gated, 4'h4);
        wake = 4'h4;
        for (int t = 1; t <= 5; t++) begin
            step();
            wake = 4'h0; sleep = 4'h0;
            chk($sformatf("d2_t%0d_en2", t), {3'b0, en[2]}, (t >= 2) ? 4'h1 : 4'h0);
            chk($sformatf("d2_t%0d_done", t), done, (t == 4) ? 4'h4 : 4'h0);
        end

        // Asynchronous reset in the middle of a wake
        sleep = 4'h9;
        for (int c = 0; c < 9; c++) step();
        chk("rstmid_gated", gated, 4'h9);
        wake = 4'h1; sleep = 4'h8;
        step();
        wake = 4'h0;
        chk("rstmid_pend_gated", gated, 4'h9);
        step();
        chk("rstmid_wake_en", en, 4'h7);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_en", en, 4'hF);
        chk("rstmid_gated0", gated, 4'h0);
        chk("rstmid_done", done, 4'h0);
        sleep = 4'h0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("rstmid_nopulse%0d", c), done, 4'h0);
        end

        // Contention: all four wake together, serialized 0,1,2,3
        sleep = 4'hF;
        for (int c = 0; c < 9; c++) step();
        chk("cont_all_gated", gated, 4'hF);
        chk("cont_all_en", en, 4'h0);
        wake = 4'hF; sleep = 4'h0;
        for (int t = 1; t <= 14; t++) begin
            step();
            wake = 4'h0;
            for (int i = 0; i < 4; i++) begin
                e_en[i] = (t >= 2 + 3 * i);
                e_d[i]  = (t == 4 + 3 * i);
            end
            e_g = ~e_en;
            chk($sformatf("cont_t%0d_en", t), en, e_en);
            chk($sformatf("cont_t%0d_gated", t), gated, e_g);
            chk($sformatf("cont_t%0d_done", t), done, e_d);
        end

        // Test mode: combinational override, FSMs keep running
        sleep = 4'hF;
        for (int c = 0; c < 9; c++) step();
        chk("tm_pre_en", en, 4'h0);
        #2 test_en = 1'b1;
        #1;
        chk("tm_comb_en", en, 4'hF);
        chk("tm_comb_gated", gated, 4'hF);
        step(); step();
        chk("tm_hold_gated", gated, 4'hF);
        wake = 4'hF; sleep = 4'h0;
        step();
        wake = 4'h0;
        chk("tm_t1_gated", gated, 4'hF);
        step();
        chk("tm_t2_gated", gated, 4'hE);
        chk("tm_t2_en", en, 4'hF);
        for (int c = 0; c < 12; c++) step();
        test_en = 1'b0;
        #1;
        chk("tm_end_en", en, 4'hF);
        chk("tm_end_gated", gated, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
